// File: rtl/rr_arbiter_4_df.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_4_df
//  Description : Four-requester round-robin arbiter for one shared resource.
//                A grant is held until its owner drops the request; a
//                one-cycle dead gap separates any two grants, and priority
//                rotates past the last owner. Grant lines are active-low
//                one-hot, with the encoded owner index alongside.
//  Optional    : ARB_TIMEOUT_EN - when defined, a grant is revoked after
//                HOLD_MAX cycles and timeout pulses for one cycle.
//  Ports       : clk         - single clock, rising edge
//                reset       - synchronous active-high reset
//                enable_n    - active-low enable for issuing new grants
//                req[0:3]    - active-high requests, req[i] = requester i
//                gnt_n[0:3]  - registered active-low one-hot grant
//                grant_id    - index of current/last owner
//                grant_valid - high while any gnt_n bit is low
//                timeout     - one-cycle pulse after a timeout revocation
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4_df #(
    parameter int HOLD_MAX = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_n,
    input  logic [0:3] req,
    output logic [0:3] gnt_n,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    logic [0:0] r_state,   w_state_nxt;
    logic [1:0] r_owner,   w_owner_nxt;
    logic [1:0] r_last_id, w_last_id_nxt;
    logic [0:3] r_gnt_n,   w_gnt_n_nxt;
    logic       r_timeout, w_timeout_nxt;

    logic [1:0] w_pick;
    logic [1:0] w_cand;
    logic       w_any;
    logic       w_owner_req;
    logic       w_timeout_hit;

    assign w_owner_req = req[r_owner];

    // Scan last_id+1 .. last_id+4 (mod 4); the last owner is examined last,
    // which gives it the lowest priority in the next arbitration.
    always_comb begin
        w_pick = 2'b00;
        w_any  = 1'b0;
        w_cand = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last_id + 2'(k);
            if (!w_any && req[w_cand]) begin
                w_pick = w_cand;
                w_any  = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_MAX - 1);

    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;

    // Counter sits at zero in IDLE, so it is already cleared on GRANT entry.
    always_comb begin
        w_hold_cnt_nxt = '0;
        if (r_state == c_st_grant) begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // A same-edge release wins over timeout, so the owner's request is part
    // of the hit condition.
    assign w_timeout_hit = (r_state == c_st_grant) && (r_hold_cnt == c_hold_last) && w_owner_req;
`else
    assign w_timeout_hit = 1'b0;

    // The hold parameters only size the optional counter; keep a width sanity
    // check so they remain meaningful in this build too.
    if ((1 << HOLD_W) <= HOLD_MAX) begin : g_hold_w_check
        $error("HOLD_W too narrow for HOLD_MAX");
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_id_nxt = r_last_id;
        w_gnt_n_nxt   = r_gnt_n;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_gnt_n_nxt = 4'b1111;
                if (!enable_n && w_any) begin
                    w_state_nxt         = c_st_grant;
                    w_owner_nxt         = w_pick;
                    w_last_id_nxt       = w_pick;
                    w_gnt_n_nxt[w_pick] = 1'b0;
                end
            end
            c_st_grant: begin
                // Other requests and enable_n are deliberately ignored here.
                if (!w_owner_req) begin
                    w_state_nxt = c_st_idle;
                    w_gnt_n_nxt = 4'b1111;
                end else if (w_timeout_hit) begin
                    w_state_nxt   = c_st_idle;
                    w_gnt_n_nxt   = 4'b1111;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_gnt_n_nxt = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_owner   <= 2'b00;
            r_last_id <= 2'd3;
            r_gnt_n   <= 4'b1111;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last_id <= w_last_id_nxt;
            r_gnt_n   <= w_gnt_n_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign gnt_n       = r_gnt_n;
    assign grant_id    = r_owner;
    assign grant_valid = ~&r_gnt_n;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4_df.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_4_df
//  Description : Directed self-checking bench for rr_arbiter_4_df. Covers
//                reset, rotation, enable gating, hold/ignore, reset mid-grant
//                and, depending on ARB_TIMEOUT_EN, timeout or indefinite hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4_df;

    logic       clk;
    logic       reset;
    logic       enable_n;
    logic [0:3] req;
    logic [0:3] gnt_n;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int n_tests;
    int n_fail;

    rr_arbiter_4_df #(
        .HOLD_MAX (16),
        .HOLD_W   (5)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable_n    (enable_n),
        .req         (req),
        .gnt_n       (gnt_n),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Expected active-low grant for requester i.
    function automatic logic [0:3] gn(input int i);
        logic [0:3] v;
        v    = 4'b1111;
        v[i] = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input int id);
        chk({tag, "_gnt_n"}, 32'(gnt_n), 32'(gn(id)));
        chk({tag, "_id"}, 32'(grant_id), 32'(id));
        chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt_n"}, 32'(gnt_n), 32'hF);
        chk({tag, "_valid"}, 32'(grant_valid), 32'd0);
    endtask

    // Invariant: never more than one grant line low.
    always @(negedge clk) begin
        if (!reset) begin
            chk("onehot", 32'($countones(~gnt_n) <= 1), 32'd1);
        end
    end

    initial begin
        int exp_seq [4] = '{1, 2, 3, 0};
        int prev;
        n_tests  = 0;
        n_fail   = 0;
        reset    = 1'b1;
        enable_n = 1'b0;
        req      = 4'b1111;

        // Reset
        tick();
        tick();
        chk_idle("rst");
        chk("rst_id", 32'(grant_id), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        tick();
        chk_grant("first", 0);

        // Rotation with one-cycle release by each owner
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            req       = 4'b1111;
            req[prev] = 1'b0;
            tick();
            chk_idle("rot_gap");
            req = 4'b1111;
            tick();
            chk_grant("rot", exp_seq[n]);
            prev = exp_seq[n];
        end
        req = 4'b0000;
        tick();
        chk_idle("rot_end");

        // Enable gating, requester 2 only
        enable_n = 1'b1;
        req      = 4'b0010;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk_idle("en_block");
        end
        enable_n = 1'b0;
        tick();
        chk_grant("en_go", 2);
        enable_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk_grant("en_hold", 2);
        end
        req = 4'b0000;
        tick();
        chk_idle("en_rel");
        chk("en_rel_id_kept", 32'(grant_id), 32'd2);
        enable_n = 1'b0;

        // Hold and ignore other requests
        req = 4'b0100;
        tick();
        chk_grant("hold", 1);
        req = 4'b0101;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk_grant("hold_ign", 1);
        end
        req = 4'b0001;
        tick();
        chk_idle("hold_gap");
        tick();
        chk_grant("hold_next", 3);

        // Reset in the middle of a grant
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        chk_grant("mid_pre", 1);
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        chk_idle("mid_rst");
        reset = 1'b0;
        tick();
        chk_grant("mid_after", 0);

        // Long hold by requester 0
        req = 4'b0000;
        tick();
        req = 4'b1000;
        tick();
        chk_grant("long_first", 0);
`ifdef ARB_TIMEOUT_EN
        for (int n = 0; n < 15; n++) begin
            tick();
            chk_grant("to_hold", 0);
            chk("to_hold_pulse", 32'(timeout), 32'd0);
        end
        tick();
        chk_idle("to_revoke");
        chk("to_pulse", 32'(timeout), 32'd1);
        req = 4'b1001;
        tick();
        chk_grant("to_next", 3);
        chk("to_pulse_end", 32'(timeout), 32'd0);
`else
        for (int n = 0; n < 20; n++) begin
            tick();
            chk_grant("inf_hold", 0);
            chk("inf_timeout", 32'(timeout), 32'd0);
        end
        req = 4'b0001;
        tick();
        chk_idle("inf_rel");
        tick();
        chk_grant("inf_next", 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
